// File: rtl/fifo_fwft_adapter_pkg.sv
// rtl/fifo_fwft_adapter_pkg.sv - shared constants and index helpers for the FIFO read-side FWFT stage
package fifo_fwft_adapter_pkg;

  localparam int FWFT_DEPTH = 3;
  localparam int FWFT_CNT_W = 2;

  typedef logic [1:0] fwft_idx_t;

  // Indices wrap 2 -> 0; value 3 is never produced.
  function automatic fwft_idx_t fwft_idx_inc(input fwft_idx_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_fwft_adapter_buf3.sv
// rtl/fifo_fwft_adapter_buf3.sv - 3-entry circular register buffer (fwft_buf3)
module fwft_buf3
  import fifo_fwft_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [FWFT_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] mem_q [FWFT_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FWFT_DEPTH];
  fwft_idx_t             head_q, head_d;
  fwft_idx_t             tail_q, tail_d;
  logic [FWFT_CNT_W-1:0] count_q, count_d;

  // With count=1 a simultaneous push/pop reads the old head; the write goes to tail.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = fwft_idx_inc(tail_q);
    end
    if (pop) begin
      head_d = fwft_idx_inc(head_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fifo_fwft_adapter.sv
// rtl/fifo_fwft_adapter.sv - converts the FIFO's one-cycle-latency read port into a FWFT valid/ready stream
module fifo_fwft_adapter
  import fifo_fwft_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            m_count
);

  logic                  inflight_q, inflight_d;
  logic [FWFT_CNT_W-1:0] held;
  logic [2:0]            occupancy;
  logic                  pop;

  fwft_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (rclk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head_data (m_data),
    .count     (held)
  );

  // Credit check counts the word still in flight, so a stall never overflows the buffer.
  always_comb begin
    occupancy  = {1'b0, held} + {2'b00, inflight_q};
    fifo_r_en  = !rst && !fifo_empty && (occupancy < 3'(FWFT_DEPTH));
    inflight_d = fifo_r_en;
    m_valid    = (held != '0);
    pop        = m_valid && m_ready;
    m_count    = held;
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst) begin
      assert (occupancy <= 3'(FWFT_DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// tb/tb_fifo_fwft_adapter.sv - self-checking bench for fifo_fwft_adapter
module tb_fifo_fwft_adapter;

  logic       rclk;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] fifo_rdata;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_count;

  fifo_fwft_adapter #(.DATA_WIDTH(8)) dut (
    .rclk       (rclk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_rdata (fifo_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_count    (m_count)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  int         m_inflight = 0;
  logic [7:0] m_pending = 8'h00;
  logic       hold_empty = 1'b0;
  int         delivered = 0;
  int         ren_count = 0;
  int         s_ren, s_valid, s_data, s_cnt;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load(input logic [7:0] w);
    src.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic run_cycle();
    int exp_ren;
    int pop;
    fifo_empty = (src.size() == 0) || hold_empty;
    #1;
    s_ren   = 32'(fifo_r_en);
    s_valid = 32'(m_valid);
    s_data  = 32'(m_data);
    s_cnt   = 32'(m_count);
    exp_ren = int'(!fifo_empty && (mq.size() + m_inflight < 3));
    chk("r_en", s_ren, exp_ren);
    if (fifo_empty) chk("r_en_while_empty", s_ren, 0);
    chk("m_count", s_cnt, mq.size());
    chk("m_valid", s_valid, int'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", s_data, 32'(mq[0]));
    pop = int'(m_valid && m_ready);
    if (pop != 0) begin
      if (exp_q.size() != 0) chk("order", s_data, 32'(exp_q.pop_front()));
      else chk("spurious_word", s_data, -1);
      delivered++;
    end
    if (s_ren != 0) ren_count++;
    @(posedge rclk);
    #1;
    if (pop != 0 && mq.size() != 0) void'(mq.pop_front());
    if (m_inflight != 0) mq.push_back(m_pending);
    m_inflight = s_ren;
    if (s_ren != 0 && src.size() != 0) begin
      fifo_rdata = src.pop_front();
      m_pending  = fifo_rdata;
    end else begin
      fifo_rdata = 8'($urandom);
    end
    @(negedge rclk);
  endtask

  task automatic model_clear();
    src.delete();
    exp_q.delete();
    mq.delete();
    m_inflight = 0;
  endtask

  initial begin
    int start;
    int added;
    int budget;
    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_rdata = 8'h00;
    m_ready    = 1'b0;
    #2;
    chk("reset_r_en", 32'(fifo_r_en), 0);
    chk("reset_valid", 32'(m_valid), 0);
    chk("reset_data", 32'(m_data), 0);
    chk("reset_count", 32'(m_count), 0);
    @(negedge rclk);
    rst = 1'b0;

    // Single word.
    load(8'hA5);
    m_ready = 1'b1;
    run_cycle(); chk("single_c0_ren", s_ren, 1);
    run_cycle(); chk("single_c1_valid", s_valid, 0);
    run_cycle(); chk("single_c2_valid", s_valid, 1); chk("single_c2_data", s_data, 32'hA5);
    run_cycle(); chk("single_c3_valid", s_valid, 0);

    // Streaming 0x01..0x08.
    for (int i = 1; i <= 8; i++) load(8'(i));
    for (int c = 0; c < 11; c++) begin
      run_cycle();
      if (c >= 2 && c <= 9) begin
        chk("stream_valid", s_valid, 1);
        chk("stream_data", s_data, c - 1);
      end else begin
        chk("stream_idle", s_valid, 0);
      end
    end

    // Backpressure 0x10..0x14.
    for (int i = 0; i < 5; i++) load(8'(8'h10 + i));
    m_ready   = 1'b0;
    ren_count = 0;
    for (int c = 0; c < 6; c++) run_cycle();
    chk("bp_ren_count", ren_count, 3);
    chk("bp_count", s_cnt, 3);
    chk("bp_data", s_data, 32'h10);
    start   = delivered;
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) run_cycle();
    chk("bp_delivered", delivered - start, 5);

    // Reset mid-stream with held=2, inflight=1.
    for (int i = 0; i < 6; i++) load(8'(8'h30 + i));
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) run_cycle();
    rst = 1'b1;
    #1;
    chk("midrst_r_en", 32'(fifo_r_en), 0);
    chk("midrst_valid", 32'(m_valid), 0);
    chk("midrst_data", 32'(m_data), 0);
    chk("midrst_count", 32'(m_count), 0);
    model_clear();
    for (int i = 0; i < 6; i++) load(8'(8'h30 + i));
    @(posedge rclk);
    #1;
    @(negedge rclk);
    rst     = 1'b0;
    m_ready = 1'b1;
    run_cycle(); chk("post_rst_count", s_cnt, 0);
    run_cycle();
    run_cycle(); chk("post_rst_head", s_data, 32'h30);
    for (int c = 0; c < 8; c++) run_cycle();

    // Wrap-around with alternating ready.
    start = delivered;
    for (int i = 0; i < 7; i++) load(8'(8'h40 + i));
    for (int c = 0; c < 24; c++) begin
      m_ready = c[0];
      run_cycle();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) run_cycle();
    chk("wrap_delivered", delivered - start, 7);

    // Random ready and random FIFO fill, 1000 words.
    start  = delivered;
    added  = 0;
    budget = 0;
    while ((delivered - start) < 1000 && budget < 20000) begin
      if (added < 1000 && $urandom_range(0, 1) == 1) begin
        load(8'($urandom));
        added++;
      end
      hold_empty = ($urandom_range(0, 3) == 0);
      m_ready    = ($urandom_range(0, 1) == 1);
      run_cycle();
      budget++;
    end
    chk("random_delivered", delivered - start, 1000);
    chk("random_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
